// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: decimal value on digits 3..2,
// count-direction glyph on digits 1..0, with the data snapshotted once per frame.
module sevenseg_scan_driver #(
  parameter int SCAN_DIV = 131072,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       direction,
  input  logic       blank,
  output logic [0:6] out,
  output logic [3:0] AN,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [0:6]       GLYPH_UP = 7'b0011100;
  localparam logic [0:6]       GLYPH_DN = 7'b1100010;

  logic [CNT_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [3:0]       r_snap_val;
  logic             r_snap_dir;
  logic [3:0]       r_an;
  logic [0:6]       r_out;
  logic             r_tick;

  logic             w_scan;
  logic             w_wrap;
  logic [1:0]       w_idx_nxt;
  logic [3:0]       w_sv_nxt;
  logic             w_sd_nxt;
  logic [0:6]       w_glyph;
  logic [3:0]       w_an_nxt;

  function automatic logic [0:6] seg_digit(input logic [3:0] d);
    logic [0:6] g;
    case (d)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b0100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  function automatic logic [0:6] digit_content(input logic [1:0] idx,
                                               input logic [3:0] sv,
                                               input logic       sd);
    logic       tens;
    logic [3:0] ones;
    logic [0:6] g;
    tens = (sv >= 4'd10);
    ones = tens ? (sv - 4'd10) : sv;
    case (idx)
      2'd3:    g = seg_digit({3'b000, tens});
      2'd2:    g = seg_digit(ones);
      default: g = sd ? GLYPH_UP : GLYPH_DN;
    endcase
    return g;
  endfunction

  // Outputs are built from the post-edge index and snapshot so they change in step with it.
  always_comb begin
    w_scan    = (r_div == DIV_MAX);
    w_wrap    = w_scan && (r_idx == 2'd0);
    w_idx_nxt = r_idx - 2'd1;
    w_sv_nxt  = w_wrap ? value     : r_snap_val;
    w_sd_nxt  = w_wrap ? direction : r_snap_dir;
    w_glyph   = digit_content(w_idx_nxt, w_sv_nxt, w_sd_nxt);
    w_an_nxt  = ~(4'b0001 << w_idx_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_idx      <= 2'd3;
      r_snap_val <= 4'd0;
      r_snap_dir <= 1'b1;
      r_an       <= 4'b0111;
      r_out      <= 7'b0000001;
      r_tick     <= 1'b0;
    end else begin
      r_div  <= w_scan ? '0 : r_div + CNT_W'(1);
      r_tick <= w_wrap;
      if (w_scan) begin
        r_idx      <= w_idx_nxt;
        r_snap_val <= w_sv_nxt;
        r_snap_dir <= w_sd_nxt;
        r_an       <= w_an_nxt;
        r_out      <= w_glyph;
      end
    end
  end

  assign AN         = blank ? 4'b1111 : r_an;
  assign out        = r_out;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed plus randomized bench for sevenseg_scan_driver (SCAN_DIV=4), checked each
// cycle against a model derived from the elapsed clock count since reset.
module tb_sevenseg_scan_driver;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] value;
  logic       direction;
  logic       blank;
  logic [0:6] seg_out;
  logic [3:0] an;
  logic       tick;

  int n_vec = 0;
  int n_err = 0;

  sevenseg_scan_driver #(.SCAN_DIV(SD), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .value(value), .direction(direction),
    .blank(blank), .out(seg_out), .AN(an), .frame_tick(tick)
  );

  always #5 clk = ~clk;

  // Model state: k = rising edges since reset; snapshot captured every 4*SD edges.
  int         m_k  = 0;
  logic [3:0] m_sv = 4'd0;
  logic       m_sd = 1'b1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k  = 0;
      m_sv = 4'd0;
      m_sd = 1'b1;
    end else begin
      m_k = m_k + 1;
      if (m_k % (4 * SD) == 0) begin
        m_sv = value;
        m_sd = direction;
      end
    end
  end

  logic [0:6] glyph_tab [10];
  initial begin
    glyph_tab[0] = 7'b0000001; glyph_tab[1] = 7'b1001111;
    glyph_tab[2] = 7'b0010010; glyph_tab[3] = 7'b0000110;
    glyph_tab[4] = 7'b1001100; glyph_tab[5] = 7'b0100100;
    glyph_tab[6] = 7'b0100000; glyph_tab[7] = 7'b0001111;
    glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0000100;
  end

  function automatic int model_idx();
    return 3 - ((m_k / SD) % 4);
  endfunction

  task automatic check(input string tag);
    int         idx;
    logic [0:6] e_out;
    logic [3:0] e_an;
    logic       e_tick;
    idx = model_idx();
    case (idx)
      3:       e_out = glyph_tab[m_sv / 10];
      2:       e_out = glyph_tab[m_sv % 10];
      default: e_out = m_sd ? 7'b0011100 : 7'b1100010;
    endcase
    e_an   = blank ? 4'b1111 : ~(4'b0001 << idx);
    e_tick = (m_k > 0) && (m_k % (4 * SD) == 0);
    n_vec++;
    assert (seg_out === e_out) else begin
      n_err++;
      $error("FAIL %s_out k=%0d observed=%b expected=%b", tag, m_k, seg_out, e_out);
    end
    n_vec++;
    assert (an === e_an) else begin
      n_err++;
      $error("FAIL %s_an k=%0d observed=%b expected=%b", tag, m_k, an, e_an);
    end
    n_vec++;
    assert (tick === e_tick) else begin
      n_err++;
      $error("FAIL %s_tick k=%0d observed=%b expected=%b", tag, m_k, tick, e_tick);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag);
    end
  endtask

  task automatic wait_idx(input int target, input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    check(tag);
    while (model_idx() != target && guard < 32) begin
      @(negedge clk);
      check(tag);
      guard++;
    end
    n_vec++;
    assert (model_idx() == target) else begin
      n_err++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, model_idx(), target);
    end
  endtask

  initial begin
    reset = 1'b1; value = 4'd7; direction = 1'b1; blank = 1'b0;
    run(2, "reset");
    reset = 1'b0;
    run(40, "t1_hold7up");

    value = 4'd13; direction = 1'b0;
    run(36, "t2_13dn");

    value = 4'd3; direction = 1'b1;
    wait_idx(3, "t3_sync");
    run(20, "t3_pre");
    wait_idx(2, "t3_mid");
    run(1, "t3_mid");
    value = 4'd12;
    run(40, "t3_after");

    for (int v = 0; v < 16; v++) begin
      value = 4'(v);
      direction = v[0];
      run(4 * SD, "t4_sweep");
    end

    run(5, "t5_pre");
    blank = 1'b1;
    run(10, "t5_blank");
    blank = 1'b0;
    run(20, "t5_resume");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) direction = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) blank = ~blank;
      run(1, "rand");
    end
    blank = 1'b0;

    wait_idx(1, "t6_sync");
    #2 reset = 1'b1;
    #1 check("t6_async");
    run(3, "t6_held");
    #2 reset = 1'b0;
    value = 4'd9; direction = 1'b0;
    run(40, "t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
